// File: rtl/mc_core.sv
// Multi-cycle RV32I/RV32E core: datapath and FSM control sharing a single
// memory port for instruction fetch and data access.
module mc_core #(
  parameter int unsigned         XLEN       = 32,
  parameter int unsigned         REG_ADDR_W = 5,
  parameter logic [XLEN-1:0]     RESET_PC   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("mc_core: XLEN must be 32");
  end
  if (REG_ADDR_W < 1 || REG_ADDR_W > 5) begin : g_bad_regw
    $error("mc_core: REG_ADDR_W must be 1..5");
  end

  localparam int unsigned NREG  = 1 << REG_ADDR_W;
  localparam logic [5:0]  NREG6 = 6'(NREG);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_LUI, S_HALT
  } state_t;

  state_t r_state, w_state_nx, w_dec_nx;

  logic [XLEN-1:0] r_pc, r_oldpc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [XLEN-1:0] r_rf [NREG];

  logic [6:0] w_op, w_f7;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;
  logic       w_rd_ok, w_rs1_ok, w_rs2_ok;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic [XLEN-1:0] w_alu_b, w_alu_res, w_maddr, w_jalr_t;
  logic [4:0]      w_shamt;
  logic            w_br_taken;

  logic            w_ir_we, w_pc_we, w_dec_we, w_alu_we, w_mdr_we, w_rf_we;
  logic [XLEN-1:0] w_pc_nx, w_alu_nx, w_rf_wd;

  assign w_op  = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  assign w_rd_ok  = ({1'b0, w_rd}  < NREG6);
  assign w_rs1_ok = ({1'b0, w_rs1} < NREG6);
  assign w_rs2_ok = ({1'b0, w_rs2} < NREG6);

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};

  assign w_rs1_val = (w_rs1 == '0) ? '0 : r_rf[w_rs1[REG_ADDR_W-1:0]];
  assign w_rs2_val = (w_rs2 == '0) ? '0 : r_rf[w_rs2[REG_ADDR_W-1:0]];

  assign w_maddr  = r_a + ((w_op == OP_SW) ? w_imm_s : w_imm_i);
  assign w_jalr_t = r_a + w_imm_i;

  // Legality is decided on the fields each format actually uses.
  always_comb begin
    w_dec_nx = S_HALT;
    case (w_op)
      OP_R:
        if (w_rd_ok && w_rs1_ok && w_rs2_ok &&
            (w_f7 == 7'b0 ||
             (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
          w_dec_nx = S_EXEC_R;
      OP_I:
        if (w_rd_ok && w_rs1_ok &&
            ((w_f3 == 3'b001) ? (w_f7 == 7'b0) :
             (w_f3 == 3'b101) ? (w_f7 == 7'b0 || w_f7 == 7'b0100000) : 1'b1))
          w_dec_nx = S_EXEC_I;
      OP_LW:   if (w_f3 == 3'b010 && w_rd_ok && w_rs1_ok)  w_dec_nx = S_MEM_ADDR;
      OP_SW:   if (w_f3 == 3'b010 && w_rs1_ok && w_rs2_ok) w_dec_nx = S_MEM_ADDR;
      OP_BR:   if (w_f3 != 3'b010 && w_f3 != 3'b011 && w_rs1_ok && w_rs2_ok)
                 w_dec_nx = S_BRANCH;
      OP_JAL:  if (w_rd_ok) w_dec_nx = S_JAL;
      OP_JALR: if (w_f3 == 3'b000 && w_rd_ok && w_rs1_ok) w_dec_nx = S_JALR;
      OP_LUI:  if (w_rd_ok) w_dec_nx = S_LUI;
      default: w_dec_nx = S_HALT;
    endcase
  end

  assign w_alu_b = (r_state == S_EXEC_R) ? r_b : w_imm_i;
  assign w_shamt = w_alu_b[4:0];

  always_comb begin
    w_alu_res = '0;
    case (w_f3)
      3'b000: w_alu_res = (r_state == S_EXEC_R && w_f7[5]) ? r_a - w_alu_b : r_a + w_alu_b;
      3'b001: w_alu_res = r_a << w_shamt;
      3'b010: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      3'b011: w_alu_res = {{(XLEN-1){1'b0}}, (r_a < w_alu_b)};
      3'b100: w_alu_res = r_a ^ w_alu_b;
      3'b101: w_alu_res = w_f7[5] ? XLEN'($signed(r_a) >>> w_shamt) : r_a >> w_shamt;
      3'b110: w_alu_res = r_a | w_alu_b;
      default: w_alu_res = r_a & w_alu_b;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (w_f3)
      3'b000: w_br_taken = (r_a == r_b);
      3'b001: w_br_taken = (r_a != r_b);
      3'b100: w_br_taken = ($signed(r_a) <  $signed(r_b));
      3'b101: w_br_taken = ($signed(r_a) >= $signed(r_b));
      3'b110: w_br_taken = (r_a <  r_b);
      3'b111: w_br_taken = (r_a >= r_b);
      default: w_br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = r_pc;
    mem_wdata  = '0;
    retire     = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_nx    = r_pc + 32'd4;
    w_dec_we   = 1'b0;
    w_alu_we   = 1'b0;
    w_alu_nx   = w_alu_res;
    w_mdr_we   = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_wd    = r_pc;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_we    = 1'b1;
          w_pc_we    = 1'b1;
          w_state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        w_dec_we   = 1'b1;
        w_state_nx = w_dec_nx;
      end
      S_EXEC_R, S_EXEC_I: begin
        w_alu_we   = 1'b1;
        w_state_nx = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_rf_we    = 1'b1;
        w_rf_wd    = r_aluout;
        retire     = 1'b1;
        w_state_nx = S_FETCH;
      end
      S_MEM_ADDR: begin
        if (w_maddr[1:0] != 2'b00) begin
          w_state_nx = S_HALT;
        end else begin
          w_alu_we   = 1'b1;
          w_alu_nx   = w_maddr;
          w_state_nx = (w_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = r_aluout;
        if (mem_ready) begin
          w_mdr_we   = 1'b1;
          w_state_nx = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        w_rf_we    = 1'b1;
        w_rf_wd    = r_mdr;
        retire     = 1'b1;
        w_state_nx = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_aluout;
        mem_wdata = r_b;
        if (mem_ready) begin
          retire     = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_BRANCH: begin
        if (w_br_taken && r_aluout[1:0] != 2'b00) begin
          w_state_nx = S_HALT;
        end else begin
          w_pc_we    = w_br_taken;
          w_pc_nx    = r_aluout;
          retire     = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_JAL: begin
        if (r_aluout[1:0] != 2'b00) begin
          w_state_nx = S_HALT;
        end else begin
          w_rf_we    = 1'b1;
          w_pc_we    = 1'b1;
          w_pc_nx    = r_aluout;
          retire     = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_JALR: begin
        w_rf_we    = 1'b1;
        w_pc_we    = 1'b1;
        w_pc_nx    = {w_jalr_t[XLEN-1:1], 1'b0};
        retire     = 1'b1;
        w_state_nx = S_FETCH;
      end
      S_LUI: begin
        w_rf_we    = 1'b1;
        w_rf_wd    = w_imm_u;
        retire     = 1'b1;
        w_state_nx = S_FETCH;
      end
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_HALT;
    endcase
    // Reset abandons any outstanding access in the same cycle.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_oldpc  <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      if (w_ir_we) begin
        r_ir    <= mem_rdata;
        r_oldpc <= r_pc;
      end
      if (w_pc_we) r_pc <= w_pc_nx;
      if (w_dec_we) begin
        r_a      <= w_rs1_val;
        r_b      <= w_rs2_val;
        r_aluout <= r_oldpc + ((w_op == OP_JAL) ? w_imm_j : w_imm_b);
      end
      if (w_alu_we) r_aluout <= w_alu_nx;
      if (w_mdr_we) r_mdr <= mem_rdata;
      if (w_rf_we && w_rd != '0) r_rf[w_rd[REG_ADDR_W-1:0]] <= w_rf_wd;
    end
  end

  assign pc     = r_pc;
  assign halted = (r_state == S_HALT) && !rst;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: an RV32I instance running a small program
// against a wait-state memory model, plus an RV32E instance hitting an illegal register.
module tb_mc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic        e_req, e_we, e_ready, e_retire, e_halted;
  logic [31:0] e_addr, e_wdata, e_rdata, e_pc;

  mc_core #(.XLEN(32), .REG_ADDR_W(5), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .retire(retire), .halted(halted)
  );

  mc_core #(.XLEN(32), .REG_ADDR_W(4), .RESET_PC(32'h0000_0100)) u_dut_e (
    .clk(clk), .rst(rst), .mem_req(e_req), .mem_we(e_we),
    .mem_addr(e_addr), .mem_wdata(e_wdata), .mem_rdata(e_rdata),
    .mem_ready(e_ready), .pc(e_pc), .retire(e_retire), .halted(e_halted)
  );

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] prog(input logic [5:0] idx);
    case (idx)
      6'd0:  return enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'b0010011);  // addi x1,x0,5
      6'd1:  return enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, 7'b0010011);  // addi x2,x1,-7
      6'd2:  return enc_s(12'h008, 5'd2, 5'd0);                      // sw x2,8(x0)
      6'd3:  return enc_i(12'h008, 5'd0, 3'b010, 5'd3, 7'b0000011);  // lw x3,8(x0)
      6'd4:  return enc_s(12'h080, 5'd3, 5'd0);                      // sw x3,0x80(x0)
      6'd5:  return enc_b(13'd8, 5'd1, 5'd2, 3'b100);                // blt x2,x1,+8
      6'd6:  return enc_s(12'h098, 5'd0, 5'd0);                      // skipped
      6'd7:  return enc_b(13'd8, 5'd1, 5'd2, 3'b110);                // bltu x2,x1,+8
      6'd8:  return enc_j(21'd12, 5'd1);                             // jal x1,+12
      6'd9:  return enc_s(12'h084, 5'd1, 5'd0);                      // sw x1,0x84(x0)
      6'd10: return enc_j(21'd8, 5'd0);                              // jal x0,+8
      6'd11: return enc_i(12'd1, 5'd1, 3'b000, 5'd0, 7'b1100111);    // jalr x0,1(x1)
      6'd12: return enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);    // addi x0,x0,9
      6'd13: return enc_s(12'h088, 5'd0, 5'd0);                      // sw x0,0x88(x0)
      6'd14: return {20'h12345, 5'd4, 7'b0110111};                   // lui x4,0x12345
      6'd15: return enc_s(12'h08C, 5'd4, 5'd0);                      // sw x4,0x8C(x0)
      6'd16: return enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5);     // sub x5,x1,x2
      6'd17: return enc_s(12'h090, 5'd5, 5'd0);                      // sw x5,0x90(x0)
      6'd18: return enc_r(7'b0000000, 5'd1, 5'd2, 3'b101, 5'd6);     // srl x6,x2,x1
      6'd19: return enc_s(12'h094, 5'd6, 5'd0);                      // sw x6,0x94(x0)
      6'd20: return enc_i(12'h006, 5'd0, 3'b010, 5'd7, 7'b0000011);  // lw x7,6(x0)
      6'd34: return 32'hDEAD_BEEF;
      6'd38: return 32'hCAFE_F00D;
      default: return 32'h0000_0000;
    endcase
  endfunction

  logic [31:0] dmem [64];
  logic [63:0] written = '0;
  logic [2:0]  wcnt = '0;
  logic [2:0]  need;
  int          cyc = 0;

  function automatic logic [31:0] rd_word(input logic [5:0] idx);
    return written[idx] ? dmem[idx] : prog(idx);
  endfunction

  // Fetch at 0x40 waits 2 cycles; data accesses to 0x08 wait 3 cycles.
  assign need      = (mem_addr == pc) ? ((mem_addr == 32'h40) ? 3'd2 : 3'd0)
                                      : ((mem_addr == 32'h08) ? 3'd3 : 3'd0);
  assign mem_ready = mem_req && (wcnt == need);
  assign mem_rdata = rd_word(mem_addr[7:2]);

  assign e_ready = e_req;
  assign e_rdata = enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd17);           // add x17,x1,x2

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ready) wcnt <= wcnt + 3'd1;
    else                       wcnt <= '0;
    if (mem_req && mem_ready && mem_we) begin
      dmem[mem_addr[7:2]]    <= mem_wdata;
      written[mem_addr[7:2]] <= 1'b1;
    end
  end

  int          cyc0 = 0;
  int          ret_cnt = 0, wr_cnt = 0, w8_cnt = 0, fcnt = 0, drd_cnt = 0;
  int          e_ret_cnt = 0, e_we_cnt = 0;
  int          ret_cyc [64];
  logic [31:0] fetch_log [64];
  logic [31:0] first_waddr = '0, first_wdata = '0, drd_addr = '0;

  always @(negedge clk) begin
    if (retire) begin
      if (ret_cnt < 64) ret_cyc[ret_cnt] <= cyc - cyc0 + 1;
      ret_cnt <= ret_cnt + 1;
    end
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        if (wr_cnt == 0) begin
          first_waddr <= mem_addr;
          first_wdata <= mem_wdata;
        end
        wr_cnt <= wr_cnt + 1;
        if (mem_addr == 32'h8) w8_cnt <= w8_cnt + 1;
      end else if (mem_addr == pc) begin
        if (fcnt < 64) fetch_log[fcnt] <= mem_addr;
        fcnt <= fcnt + 1;
      end else begin
        drd_cnt  <= drd_cnt + 1;
        drd_addr <= mem_addr;
      end
    end
    if (e_retire)      e_ret_cnt <= e_ret_cnt + 1;
    if (e_req && e_we) e_we_cnt  <= e_we_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we",  {31'b0, mem_we},  32'd0);
    chk("rst_retire",  {31'b0, retire},  32'd0);
    chk("rst_halted",  {31'b0, halted},  32'd0);
    chk("rst_pc",      pc,               32'h0);
    chk("rst_e_pc",    e_pc,             32'h100);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cyc0 = cyc;
    chk("c1_mem_req",  {31'b0, mem_req}, 32'd1);
    chk("c1_mem_addr", mem_addr,         32'h0);
    chk("c1_e_req",    {31'b0, e_req},   32'd1);
    chk("c1_e_addr",   e_addr,           32'h100);
    @(negedge clk);
    chk("e_dec_req",    {31'b0, e_req},    32'd0);
    chk("e_dec_halted", {31'b0, e_halted}, 32'd0);
    @(negedge clk);
    chk("e_halted", {31'b0, e_halted}, 32'd1);
    chk("e_halt_req", {31'b0, e_req},  32'd0);
    chk("e_pc_halt", e_pc,             32'h104);

    for (int i = 0; i < 2000 && !halted; i++) @(negedge clk);
    chk("halt_reached", {31'b0, halted}, 32'd1);

    chk("retire_1_cycle", 32'(ret_cyc[0]), 32'd4);
    chk("retire_2_cycle", 32'(ret_cyc[1]), 32'd8);
    chk("sw_wait_len",    32'(ret_cyc[2] - ret_cyc[1]), 32'd7);
    chk("lw_wait_len",    32'(ret_cyc[3] - ret_cyc[2]), 32'd8);
    chk("sw_len",         32'(ret_cyc[4] - ret_cyc[3]), 32'd4);
    chk("blt_len",        32'(ret_cyc[5] - ret_cyc[4]), 32'd3);
    chk("jal_len",        32'(ret_cyc[7] - ret_cyc[6]), 32'd3);
    chk("jalr_len",       32'(ret_cyc[8] - ret_cyc[7]), 32'd3);
    chk("lui_len",        32'(ret_cyc[13] - ret_cyc[12]), 32'd3);
    chk("sub_fetchwait_len", 32'(ret_cyc[15] - ret_cyc[14]), 32'd6);

    chk("first_waddr", first_waddr, 32'h8);
    chk("first_wdata", first_wdata, 32'hFFFF_FFFE);
    chk("writes_to_8", 32'(w8_cnt), 32'd1);
    chk("write_count", 32'(wr_cnt), 32'd7);
    chk("x3_after_lw", rd_word(6'd32), 32'hFFFF_FFFE);
    chk("x1_after_jal", rd_word(6'd33), 32'h24);
    chk("x0_after_addi", rd_word(6'd34), 32'h0);
    chk("x4_lui", rd_word(6'd35), 32'h1234_5000);
    chk("x5_sub", rd_word(6'd36), 32'h26);
    chk("x6_srl", rd_word(6'd37), 32'h0FFF_FFFF);
    chk("blt_skip_untouched", rd_word(6'd38), 32'hCAFE_F00D);

    chk("fetch_0",       fetch_log[0], 32'h00);
    chk("fetch_blt_tgt", fetch_log[6], 32'h1C);
    chk("fetch_bltu_nt", fetch_log[7], 32'h20);
    chk("fetch_jal_tgt", fetch_log[8], 32'h2C);
    chk("fetch_jalr_tgt", fetch_log[9], 32'h24);
    chk("fetch_count",   32'(fcnt), 32'd20);
    chk("data_reads",    32'(drd_cnt), 32'd1);
    chk("data_read_addr", drd_addr, 32'h8);

    repeat (4) @(negedge clk);
    chk("halt_stays",    {31'b0, halted}, 32'd1);
    chk("halt_mem_req",  {31'b0, mem_req}, 32'd0);
    chk("halt_pc",       pc, 32'h54);
    chk("retire_count",  32'(ret_cnt), 32'd19);
    chk("e_retire_count", 32'(e_ret_cnt), 32'd0);
    chk("e_write_count", 32'(e_we_cnt), 32'd0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst2_halted",   {31'b0, halted},   32'd0);
    chk("rst2_e_halted", {31'b0, e_halted}, 32'd0);
    chk("rst2_mem_req",  {31'b0, mem_req},  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_req",    {31'b0, mem_req}, 32'd1);
    chk("restart_addr",   mem_addr, 32'h0);
    chk("e_restart_req",  {31'b0, e_req}, 32'd1);
    chk("e_restart_addr", e_addr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
